ibex_mem_arbiter: RTL
=====================

# ibex_mem_arbiter

Two-to-one memory-port arbiter that merges the core's instruction-fetch and load/store interfaces onto a single memory bus using the same req/gnt/rvalid protocol. It sits between the core wrapper and a single-ported SRAM or bus bridge. It arbitrates new requests, holds a stalled request stable, and tracks the source of each outstanding transaction so in-order responses are routed back to the correct requester.

## Interface
- ADDR_WIDTH, 32, address width on all three ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, depth of response-source FIFO (power of 2, ≥1)
- STARVE_LIMIT, 4, consecutive contested data grants before instruction side is forced to win

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i / instr_gnt_o  in/out  1  fetch request / grant
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_rvalid_o / instr_err_o  out  1  fetch response valid / error
- instr_rdata_o  out  DATA_WIDTH  fetch read data
- data_req_i / data_gnt_o  in/out  1  LSU request / grant
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_addr_i / data_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  LSU address / write data
- data_rvalid_o / data_err_o  out  1  LSU response valid / error
- data_rdata_o  out  DATA_WIDTH  LSU read data
- mem_req_o / mem_gnt_i  out/in  1  memory request / grant
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_addr_o / mem_wdata_o  out  ADDR_WIDTH / DATA_WIDTH  memory address / write data
- mem_rvalid_i / mem_err_i  in  1  memory response valid / error
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  high while any transaction is outstanding

## Operation
- Requesters hold req and payload stable until gnt. The memory returns exactly one rvalid per grant, in order, no earlier than the cycle after its grant.

**Arbitration**
- Data beats instruction when both are requesting.
- A starvation counter counts data grants made while instr_req_i is high. It clears on an instruction grant or when instr_req_i is low.
- When the counter equals STARVE_LIMIT, instruction wins the next arbitration.

**Lock**
- If mem_req_o is high and mem_gnt_i is low, sel_q registers the current winner and lock_q sets.
- While lock_q is set, the locked source drives the memory port regardless of priority. lock_q clears on that source's grant.

**Request gating**
- mem_req_o = active_q & (instr_req_i | data_req_i) & ~fifo_full.
- active_q clears asynchronously on reset and sets on the first clock edge after reset release.
- fifo_full is registered, so there is no combinational path from mem_rvalid_i to mem_req_o.

**Payload mux**
- mem_* carries the selected source's payload.
- For instruction requests: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.

**Grant**
- {src}_gnt_o = mem_req_o & mem_gnt_i & (selected == src).
- The non-selected side never sees gnt.

**Source FIFO**
- Push the selected source on each handshake (mem_req_o & mem_gnt_i).
- Pop on mem_rvalid_i.
- Push and pop in the same cycle are allowed when not full; occupancy is then unchanged. Pointers wrap modulo MAX_OUTSTANDING.

**Response routing**
- {src}_rvalid_o = mem_rvalid_i & ~fifo_empty & (head == src).
- instr_rdata_o and data_rdata_o are both driven by mem_rdata_i; the err outputs are routed the same way as rvalid.
- mem_rvalid_i with the FIFO empty is a protocol violation: no rvalid is forwarded, and an assertion fires.

**Other outputs**
- busy_o = ~fifo_empty.

## Timing
- Reset values: FIFO empty, lock_q=0, sel_q=data, starvation counter=0, active_q=0. Consequently mem_req_o=0, all gnt/rvalid/err outputs=0, busy_o=0.
- Request path is combinational: req to mem_req_o in 0 cycles; mem_gnt_i to {src}_gnt_o in 0 cycles.
- Response path is combinational: mem_rvalid_i to {src}_rvalid_o in 0 cycles.
- When full, mem_req_o stays low until the cycle after a pop.
- Reset mid-transaction: the FIFO is flushed, and late rvalids are dropped by the empty-FIFO rule.
- The starvation counter saturates at STARVE_LIMIT and has width $clog2(STARVE_LIMIT+1).

## Structure
- Package ibex_mem_arb_pkg holds typedef enum logic {SRC_INSTR=1'b0, SRC_DATA=1'b1} mem_src_e and default parameter constants.
- Sub-module ibex_mem_arb_fifo: a single-bit-wide source FIFO with full/empty flags and a registered full output.
- Arbitration, lock and starvation logic stay in the top module.

## Test plan
- Both requesting, mem_gnt_i always high, STARVE_LIMIT=4 → 4 data grants, then 1 instruction grant, repeating. Responses are routed per grant order.
- instr_req_i alone, mem_gnt_i low for 3 cycles, data_req_i rising in cycle 1 → mem_addr_o stays at the instruction address until its grant; data is granted the following cycle.
- MAX_OUTSTANDING=2, rvalid withheld → after 2 grants mem_req_o=0 and busy_o=1. An rvalid at cycle N lets a new grant occur at N+1.
- Grant sequence I,D,I with rvalid latencies 1, 3, 1 → rvalids appear on instr, data, instr in order, each carrying the corresponding mem_rdata_i and mem_err_i values.
- Data write with be=4'b0011, wdata=0xDEADBEEF, addr=0x100 → mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF, mem_addr_o=0x100. A following instruction fetch drives mem_be_o=1111 and mem_we_o=0.
- rst_ni asserted with 2 transactions outstanding, then released; memory returns 2 stale rvalids → no rvalid is forwarded, busy_o=0, and the first post-reset grant routes correctly.

Source files
------------

// File: rtl/ibex_mem_arb_pkg.sv
// ibex_mem_arb_pkg: shared types and default parameters for the memory arbiter
package ibex_mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } mem_src_e;

    localparam int unsigned ADDR_WIDTH_DEF      = 32;
    localparam int unsigned DATA_WIDTH_DEF      = 32;
    localparam int unsigned MAX_OUTSTANDING_DEF = 2;
    localparam int unsigned STARVE_LIMIT_DEF    = 4;

endpackage

// File: rtl/ibex_mem_arb_fifo.sv
// ibex_mem_arb_fifo: source-tag FIFO recording which requester owns each outstanding transaction
module ibex_mem_arb_fifo
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push,
    input  logic     pop,
    input  mem_src_e wdata,
    output mem_src_e head,
    output logic     full,
    output logic     empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mem_src_e      mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt, cnt_next;
    logic          full_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cnt_next = cnt + CW'(push) - CW'(pop);
    assign head     = mem[rptr];
    assign full     = full_q;
    assign empty    = (cnt == '0);

    // tag storage; entries are only read while the count marks them valid, so no reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

    // pointers, occupancy and a registered full flag so the request path never sees rvalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop) rptr <= inc(rptr);
            cnt    <= cnt_next;
            full_q <= (cnt_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: merges instruction-fetch and load/store ports onto one req/gnt/rvalid memory bus
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic                    instr_err_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic                    mem_err_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          active_q, lock_q, fifo_full, fifo_empty, hs, pop, is_instr;
    logic [SW-1:0] starve_q;
    mem_src_e      sel, sel_q, head;

    // a locked source keeps the port; otherwise data wins unless instruction has starved
    assign sel = lock_q ? sel_q :
                 (starve_q == SW'(STARVE_LIMIT) && instr_req_i) ? SRC_INSTR :
                 data_req_i ? SRC_DATA : SRC_INSTR;

    assign is_instr  = (sel == SRC_INSTR);
    assign mem_req_o = active_q & (instr_req_i | data_req_i) & ~fifo_full;
    assign hs        = mem_req_o & mem_gnt_i;

    assign mem_addr_o  = is_instr ? instr_addr_i : data_addr_i;
    assign mem_we_o    = ~is_instr & data_we_i;
    assign mem_be_o    = is_instr ? '1 : data_be_i;
    assign mem_wdata_o = is_instr ? '0 : data_wdata_i;

    assign instr_gnt_o = hs & is_instr;
    assign data_gnt_o  = hs & ~is_instr;

    // responses with nothing outstanding (e.g. stale after reset) are swallowed here
    assign pop            = mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = pop & (head == SRC_INSTR);
    assign data_rvalid_o  = pop & (head == SRC_DATA);
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign busy_o         = ~fifo_empty;

    ibex_mem_arb_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (hs),
        .pop   (pop),
        .wdata (sel),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // hold requests off until the first clock edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) active_q <= 1'b0;
        else active_q <= 1'b1;
    end

    // freeze the winner of a stalled request so its payload stays on the bus until granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= SRC_DATA;
        end else if (mem_req_o && !mem_gnt_i) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
        end else if (hs) begin
            lock_q <= 1'b0;
        end
    end

    // count data grants taken while instruction waits, saturating at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) starve_q <= '0;
        else if (!instr_req_i || instr_gnt_o) starve_q <= '0;
        else if (data_gnt_o && starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
    end

    // the memory must never respond without an outstanding transaction
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(mem_rvalid_i && fifo_empty))
        else $warning("ibex_mem_arbiter: mem_rvalid_i with no outstanding transaction");

endmodule
